// File: rtl/test_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : test_sequencer
// Brief   : Buffers host instruction words, then flushes the core, issues the
//           words with NOP padding, drains the pipeline and reads back a result.
// Rev     : 1.0 - initial release
// ============================================================================
module test_sequencer #(
    parameter int          DEPTH        = 16,
    parameter int          NOP_GAP      = 3,
    parameter int          FLUSH_CYCLES = 4,
    parameter int          DRAIN_CYCLES = 4,
    parameter int          READ_LAT     = 1,
    parameter logic [31:0] NOP_WORD     = 32'h00000013
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        run,
    output logic        busy,
    output logic [4:0]  count,
    output logic        test_start,
    output logic        CPU_restart,
    output logic        PC_restart,
    output logic [31:0] test_pattern,
    output logic        inst_end,
    input  logic [31:0] test_value,
    output logic [31:0] result,
    output logic        result_valid
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_M1    = (FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES;
    localparam int c_M2    = (NOP_GAP > READ_LAT) ? NOP_GAP : READ_LAT;
    localparam int c_MAX   = (c_M1 > c_M2) ? c_M1 : c_M2;
    localparam int c_CW    = $clog2(c_MAX + 2);

    localparam logic [4:0]         c_DEPTH      = 5'(DEPTH);
    localparam logic [c_CW-1:0]    c_FLUSH_LAST = c_CW'(FLUSH_CYCLES - 1);
    localparam logic [c_CW-1:0]    c_DRAIN_LAST = c_CW'(DRAIN_CYCLES - 1);
    localparam logic [c_CW-1:0]    c_SLOT_LAST  = c_CW'(NOP_GAP);
    localparam logic [c_CW-1:0]    c_READ_LAST  = c_CW'(READ_LAT);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE    = c_PTR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_READ  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              r_state, w_state;
    logic [c_CW-1:0]     r_cyc, w_cyc;
    logic [4:0]          r_count, w_count;
    logic [c_PTR_W-1:0]  r_wr, w_wr, r_rd, w_rd, w_rd_inc;
    logic                r_in_ready, w_in_ready, r_busy, w_busy;
    logic                r_test_start, w_test_start, r_cpu_restart, w_cpu_restart;
    logic                r_pc_restart, w_pc_restart, r_inst_end, w_inst_end;
    logic [31:0]         r_pattern, w_pattern, r_result;
    logic                r_result_valid, w_capture, w_we, w_last_slot;
    logic [31:0]         r_buf [DEPTH];

    assign w_rd_inc    = r_rd + c_PTR_ONE;
    assign w_last_slot = ({{(5 - c_PTR_W){1'b0}}, r_rd} == (r_count - 5'd1));

    always_comb begin
        w_state       = r_state;
        w_cyc         = r_cyc + c_CW'(1);
        w_count       = r_count;
        w_wr          = r_wr;
        w_rd          = r_rd;
        w_we          = 1'b0;
        w_capture     = 1'b0;
        w_test_start  = r_test_start;
        w_cpu_restart = r_cpu_restart;
        w_pc_restart  = r_pc_restart;
        w_inst_end    = r_inst_end;
        w_pattern     = NOP_WORD;
        case (r_state)
            S_IDLE: begin
                w_cyc = '0;
                if (in_valid && (r_count < c_DEPTH)) begin
                    w_we    = 1'b1;
                    w_wr    = r_wr + c_PTR_ONE;
                    w_count = r_count + 5'd1;
                end
                // A word accepted alongside run is included in this program.
                if (run && (w_count != 5'd0)) begin
                    w_state       = S_FLUSH;
                    w_test_start  = 1'b1;
                    w_cpu_restart = 1'b0;
                    w_pc_restart  = 1'b0;
                end
            end
            S_FLUSH: begin
                if (r_cyc == c_FLUSH_LAST) begin
                    w_state       = S_ISSUE;
                    w_cyc         = '0;
                    w_rd          = '0;
                    w_cpu_restart = 1'b1;
                    w_pc_restart  = 1'b1;
                    w_pattern     = r_buf[0];
                end
            end
            S_ISSUE: begin
                if (r_cyc == c_SLOT_LAST) begin
                    w_cyc = '0;
                    if (w_last_slot) begin
                        w_state = S_DRAIN;
                    end else begin
                        w_rd      = w_rd_inc;
                        w_pattern = r_buf[w_rd_inc];
                    end
                end
            end
            S_DRAIN: begin
                if (r_cyc == c_DRAIN_LAST) begin
                    w_state    = S_READ;
                    w_cyc      = '0;
                    w_inst_end = 1'b1;
                end
            end
            S_READ: begin
                if (r_cyc == c_READ_LAST) begin
                    w_state       = S_DONE;
                    w_cyc         = '0;
                    w_capture     = 1'b1;
                    w_inst_end    = 1'b0;
                    w_test_start  = 1'b0;
                    w_cpu_restart = 1'b0;
                    w_pc_restart  = 1'b0;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
                w_cyc   = '0;
                w_count = '0;
                w_wr    = '0;
                w_rd    = '0;
            end
            default: begin
                w_state = S_IDLE;
                w_cyc   = '0;
            end
        endcase
        w_in_ready = (w_state == S_IDLE) && (w_count < c_DEPTH);
        w_busy     = (w_state != S_IDLE);
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state        <= S_IDLE;
            r_cyc          <= '0;
            r_count        <= '0;
            r_wr           <= '0;
            r_rd           <= '0;
            r_in_ready     <= 1'b1;
            r_busy         <= 1'b0;
            r_test_start   <= 1'b0;
            r_cpu_restart  <= 1'b0;
            r_pc_restart   <= 1'b0;
            r_inst_end     <= 1'b0;
            r_pattern      <= NOP_WORD;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_cyc          <= w_cyc;
            r_count        <= w_count;
            r_wr           <= w_wr;
            r_rd           <= w_rd;
            r_in_ready     <= w_in_ready;
            r_busy         <= w_busy;
            r_test_start   <= w_test_start;
            r_cpu_restart  <= w_cpu_restart;
            r_pc_restart   <= w_pc_restart;
            r_inst_end     <= w_inst_end;
            r_pattern      <= w_pattern;
            r_result_valid <= w_capture;
            if (w_capture) begin
                r_result <= test_value;
            end
        end
    end

    // Storage is intentionally left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_buf[r_wr] <= in_data;
        end
    end

    assign in_ready     = r_in_ready;
    assign busy         = r_busy;
    assign count        = r_count;
    assign test_start   = r_test_start;
    assign CPU_restart  = r_cpu_restart;
    assign PC_restart   = r_pc_restart;
    assign test_pattern = r_pattern;
    assign inst_end     = r_inst_end;
    assign result       = r_result;
    assign result_valid = r_result_valid;
endmodule
`default_nettype wire

// File: tb/tb_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_test_sequencer
// Brief   : Self-checking bench for test_sequencer against a queue-based model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_test_sequencer;
    localparam int          DEPTH        = 16;
    localparam int          NOP_GAP      = 3;
    localparam int          FLUSH_CYCLES = 4;
    localparam int          DRAIN_CYCLES = 4;
    localparam int          READ_LAT     = 1;
    localparam logic [31:0] NOP          = 32'h00000013;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        run = 1'b0;
    logic        busy;
    logic [4:0]  count;
    logic        test_start, CPU_restart, PC_restart, inst_end, result_valid;
    logic [31:0] test_pattern, result;
    logic [31:0] test_value = '0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] q_model[$];

    test_sequencer #(
        .DEPTH(DEPTH), .NOP_GAP(NOP_GAP), .FLUSH_CYCLES(FLUSH_CYCLES),
        .DRAIN_CYCLES(DRAIN_CYCLES), .READ_LAT(READ_LAT), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .run(run), .busy(busy), .count(count),
        .test_start(test_start), .CPU_restart(CPU_restart), .PC_restart(PC_restart),
        .test_pattern(test_pattern), .inst_end(inst_end), .test_value(test_value),
        .result(result), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_core_ctl"}, 32'({test_start, CPU_restart, PC_restart, inst_end}), 32'd0);
        chk({tag, "_pattern"}, test_pattern, NOP);
        chk({tag, "_rvalid"}, 32'(result_valid), 32'd0);
    endtask

    // Presents one word for one cycle; in_valid stays high for back-to-back calls.
    task automatic load_word(input logic [31:0] w);
        chk("in_ready_pre", 32'(in_ready), 32'(q_model.size() < DEPTH));
        in_valid = 1'b1;
        in_data  = w;
        if (q_model.size() < DEPTH) q_model.push_back(w);
        @(negedge clk);
        chk("count_post", 32'(count), 32'(q_model.size()));
    endtask

    task automatic load_n(input int n);
        for (int i = 0; i < n; i++) load_word($urandom);
        in_valid = 1'b0;
    endtask

    task automatic do_run(input bit with_word, input logic [31:0] extra,
                          input int poke_cyc, input int abort_len,
                          input bit fixed_tv, input logic [31:0] tv_fixed);
        logic [31:0] exp_s[$];
        logic [31:0] got[$];
        logic [31:0] last_tv;
        int n, exp_lat, cyc, ts_cnt, fl_cnt, ie_cnt, bad_idx;
        bit done, cnt_bad;
        run = 1'b1;
        if (with_word) begin
            in_valid = 1'b1;
            in_data  = extra;
            if (q_model.size() < DEPTH) q_model.push_back(extra);
        end
        n = q_model.size();
        foreach (q_model[i]) begin
            exp_s.push_back(q_model[i]);
            repeat (NOP_GAP) exp_s.push_back(NOP);
        end
        repeat (DRAIN_CYCLES) exp_s.push_back(NOP);
        exp_lat = FLUSH_CYCLES + n * (1 + NOP_GAP) + DRAIN_CYCLES + READ_LAT + 2;
        last_tv = fixed_tv ? tv_fixed : $urandom;
        test_value = last_tv;
        cyc = 0; ts_cnt = 0; fl_cnt = 0; ie_cnt = 0; done = 0; cnt_bad = 0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            run = 1'b0;
            in_valid = 1'b0;
            if (cyc == poke_cyc) begin
                run = 1'b1;
                in_valid = 1'b1;
                in_data = $urandom;
            end
            if (test_start) ts_cnt++;
            if (test_start && !CPU_restart) fl_cnt++;
            if (inst_end) ie_cnt++;
            if (CPU_restart && !inst_end) got.push_back(test_pattern);
            if (busy && count !== 5'(n)) cnt_bad = 1;
            if (abort_len > 0 && got.size() == abort_len) begin
                chk("abort_word2", got[abort_len-1], q_model[1]);
                Rst = 1'b1;
                @(negedge clk);
                chk("abort_test_start", 32'(test_start), 32'd0);
                chk("abort_count", 32'(count), 32'd0);
                chk("abort_in_ready", 32'(in_ready), 32'd1);
                chk("abort_result", result, 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                Rst = 1'b0;
                q_model.delete();
                return;
            end
            if (result_valid) begin
                done = 1;
                chk("result", result, last_tv);
                chk("latency", 32'(cyc), 32'(exp_lat));
            end
            last_tv = fixed_tv ? tv_fixed : $urandom;
            test_value = last_tv;
        end
        chk("timeout", 32'(done), 32'd1);
        chk("count_while_busy_bad", 32'(cnt_bad), 32'd0);
        chk("issue_len", 32'(got.size()), 32'(exp_s.size()));
        bad_idx = -1;
        for (int i = 0; i < got.size() && i < exp_s.size(); i++)
            if (bad_idx < 0 && got[i] !== exp_s[i]) bad_idx = i;
        chk("issue_first_bad_idx", 32'(bad_idx), 32'hFFFF_FFFF);
        chk("test_start_cycles", 32'(ts_cnt), 32'(exp_lat - 1));
        chk("flush_cycles", 32'(fl_cnt), 32'(FLUSH_CYCLES));
        chk("inst_end_cycles", 32'(ie_cnt), 32'(READ_LAT + 1));
        @(negedge clk);
        chk_idle("post_run");
        q_model.delete();
    endtask

    initial begin
        logic [31:0] prog[3];
        int n;
        prog[0] = 32'h00500093; prog[1] = 32'h00300113; prog[2] = 32'h002081B3;
        repeat (3) @(negedge clk);
        chk_idle("in_reset");
        chk("in_reset_result", result, 32'd0);
        Rst = 1'b0;
        @(negedge clk);
        chk_idle("after_reset");

        // Three-word program with a fixed readout of 8
        for (int i = 0; i < 3; i++) load_word(prog[i]);
        in_valid = 1'b0;
        do_run(0, '0, 0, 0, 1, 32'd8);

        // Overfill: 17 words offered back to back, only 16 kept
        load_n(17);
        chk("full_count", 32'(count), 32'd16);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        do_run(0, '0, 0, 0, 0, '0);

        // run with an empty buffer is ignored
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk_idle("empty_run_1");
        @(negedge clk);
        chk_idle("empty_run_2");

        // run and a word in the same cycle from count=1
        load_n(1);
        do_run(1, 32'h00100093, 0, 0, 0, '0);

        // Reset during issue of word 2, then a normal one-word run
        load_n(3);
        do_run(0, '0, 0, 1 + NOP_GAP + 1, 0, '0);
        load_n(1);
        do_run(0, '0, 0, 0, 0, '0);

        // run and in_valid while busy are ignored
        load_n(2);
        do_run(0, '0, 6, 0, 0, '0);

        // A few random program lengths
        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(1, DEPTH);
            load_n(n);
            do_run(0, '0, 0, 0, 0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/test_sequencer.md
Name: test_sequencer

Overview:
- Host-side driver for the pipelined core's test interface; sits directly upstream of the core.
- Buffers up to DEPTH instruction words from a valid/ready source (e.g. UART byte assembler).
- On a run pulse it flushes the core pipeline, then issues the buffered words as test_pattern with NOP padding, and drains the pipeline.
- It then raises inst_end, captures the core's test_value and presents it as a one-cycle result.

Parameters:
- DEPTH, 16: instruction buffer entries. Power of two, max 16; the core caps its test PC at 15.
- NOP_GAP, 3: NOP words inserted after each issued word; covers the core's lack of branch/flush and load-use stall visibility.
- FLUSH_CYCLES, 4: cycles with CPU_restart low before issue.
- DRAIN_CYCLES, 4: NOP cycles after the last gap, so the final instruction reaches writeback.
- READ_LAT, 1: cycles inst_end is held before test_value is sampled.
- NOP_WORD, 32'h00000013: padding instruction (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- Rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  host word valid.
- in_ready  out  1  buffer can accept a word.
- in_data  in  32  instruction word.
- run  in  1  start pulse.
- busy  out  1  state != IDLE.
- count  out  5  words currently buffered.
- test_start  out  1  to core; selects test mode.
- CPU_restart  out  1  to core; 0 clears pipeline registers, 1 lets test_pattern enter IF/ID.
- PC_restart  out  1  to core; 0 forces PC to 0.
- test_pattern  out  32  to core IF/ID.
- inst_end  out  1  to core data memory; requests the test_value readout.
- test_value  in  32  from core.
- result  out  32  captured test_value.
- result_valid  out  1  one-cycle pulse when result updates.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE; count=0; wr_ptr=0; rd_ptr=0; in_ready=1; busy=0; test_start=0; CPU_restart=0; PC_restart=0; inst_end=0; test_pattern=NOP_WORD; result=0; result_valid=0.
- Buffer contents are not reset.
- Reset asserted mid-operation aborts immediately to the reset values; buffered words are discarded (count=0).
- State IDLE:
  - in_ready = (count < DEPTH).
  - A word is accepted when in_valid && in_ready: buf[wr_ptr] <= in_data, wr_ptr++, count++.
  - With count == DEPTH, in_ready=0 and in_valid is ignored; the buffer does not overwrite or wrap.
  - run with count > 0 goes to FLUSH; run with count == 0 is ignored.
  - run together with an accepting in_valid in the same cycle: the word is stored first, then FLUSH is entered with the incremented count.
- Outside IDLE, in_ready=0.
- State FLUSH:
  - Outputs: test_start=1, CPU_restart=0, PC_restart=0.
  - Held for FLUSH_CYCLES cycles, counted by cyc_cnt, then go to ISSUE with rd_ptr=0.
- State ISSUE:
  - Outputs: test_start=1, CPU_restart=1, PC_restart=1.
  - Each slot is 1+NOP_GAP cycles: cycle 0 drives test_pattern=buf[rd_ptr]; the remaining cycles drive NOP_WORD.
  - rd_ptr increments at the end of each slot.
  - After the slot where rd_ptr == count-1, go to DRAIN.
- State DRAIN:
  - Outputs: test_pattern=NOP_WORD; restart signals unchanged.
  - Held for DRAIN_CYCLES, then go to READ.
- State READ:
  - inst_end=1 for READ_LAT+1 cycles.
  - On the last READ cycle, result <= test_value and result_valid pulses for 1 cycle.
  - Then go to DONE.
- State DONE (1 cycle):
  - inst_end=0, test_start=0, CPU_restart=0, PC_restart=0.
  - count, wr_ptr and rd_ptr cleared; return to IDLE.
- run asserted while busy is ignored.
- Counter rules:
  - cyc_cnt is wide enough for max(FLUSH_CYCLES, DRAIN_CYCLES, NOP_GAP, READ_LAT)+1 and is reset on every state entry.
  - Pointers are clog2(DEPTH) bits; count is 5 bits and saturates at DEPTH.
- Total latency from run to result_valid = FLUSH_CYCLES + count*(1+NOP_GAP) + DRAIN_CYCLES + READ_LAT + 2 cycles. Benches check this exactly.

Test Plan:
- Reset, then load 3 words (0x00500093, 0x00300113, 0x002081B3), run; model returns test_value=8 → test_pattern sequence is the 3 words each followed by 3 NOPs; result=8 with result_valid after 4+12+4+1+2=23 cycles.
- Push 17 words with in_valid held high → exactly 16 accepted; in_ready=0 after the 16th; count=16; the 17th word never appears on test_pattern.
- run with count=0 → busy stays 0; all core outputs remain 0/NOP.
- Assert run and in_valid with in_data=0x00100093 in the same cycle from count=1 → count=2 and both words are issued.
- Assert Rst during ISSUE at word 2 → next cycle test_start=0, count=0, in_ready=1, result unchanged at 0; a new 1-word run completes normally.
- Assert run and in_valid while busy → both ignored; count stays unchanged; one result_valid pulse only.
